// File: rtl/mmio_bank.sv
// rtl/mmio_bank.sv - memory-mapped shadow/live register bank with frame or immediate commit
module mmio_bank #(
    parameter int                SLOTS    = 16,
    parameter int                REGS     = 8,
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 13,
    parameter logic [SLOTS-1:0]  IMM_MASK = '0
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [ADDR_W-1:0]             address_i,
    input  logic [DATA_W-1:0]             data_in_i,
    input  logic                          wren_i,
    input  logic                          rden_i,
    output logic [DATA_W-1:0]             data_out_o,
    output logic                          rd_valid_o,
    output logic                          dmem_wren_o,
    input  logic [DATA_W-1:0]             dmem_q_i,
    input  logic                          frame_strobe_i,
    input  logic [SLOTS*DATA_W-1:0]       stat_in_i,
    output logic [SLOTS*REGS*DATA_W-1:0]  regs_out_o,
    output logic [SLOTS-1:0]              commit_pulse_o,
    output logic [SLOTS-1:0]              dirty_o
);
    localparam int SW = $clog2(SLOTS);
    localparam int RW = $clog2(REGS);

    logic              mmio_sel;
    logic              page_sel;
    logic [RW-1:0]     reg_idx;
    logic [SW-1:0]     slot_idx;
    logic              unused_addr_bits;

    logic [DATA_W-1:0] shadow_q [SLOTS][REGS];
    logic [DATA_W-1:0] live_q   [SLOTS][REGS];
    logic [DATA_W-1:0] stat_word [SLOTS];

    logic [SLOTS-1:0]  wr_hit;
    logic [SLOTS-1:0]  commit_d, commit_q;
    logic [SLOTS-1:0]  dirty_d, dirty_q;
    logic [DATA_W-1:0] rdata_d, rdata_q;
    logic              sel_d, sel_q;
    logic              rd_valid_q;

    // Byte address split: MMIO flag on top, then slot, page, register; low bits ignored.
    assign mmio_sel         = address_i[ADDR_W-1];
    assign reg_idx          = address_i[RW+1:2];
    assign page_sel         = address_i[RW+2];
    assign slot_idx         = address_i[SW+RW+2:RW+3];
    assign unused_addr_bits = ^address_i;

    // Unpack the flat status bus into one word per slot.
    always_comb begin
        for (int s = 0; s < SLOTS; s++) begin
            stat_word[s] = stat_in_i[s*DATA_W +: DATA_W];
        end
    end

    // Per-slot write hit, commit decision and dirty tracking.
    always_comb begin
        wr_hit   = '0;
        commit_d = '0;
        dirty_d  = '0;
        for (int s = 0; s < SLOTS; s++) begin
            wr_hit[s] = wren_i & mmio_sel & ~page_sel & (slot_idx == SW'(s));
            if (IMM_MASK[s]) begin
                commit_d[s] = wr_hit[s];
                dirty_d[s]  = 1'b0;
            end else begin
                // A write landing with the strobe is folded into this commit.
                commit_d[s] = frame_strobe_i & (dirty_q[s] | wr_hit[s]);
                dirty_d[s]  = (dirty_q[s] | wr_hit[s]) & ~frame_strobe_i;
            end
        end
    end

    // Read capture uses pre-write shadow contents; select remembers MMIO vs dmem.
    always_comb begin
        rdata_d = rdata_q;
        sel_d   = sel_q;
        if (rden_i) begin
            sel_d = mmio_sel;
            if (mmio_sel) begin
                rdata_d = page_sel ? stat_word[slot_idx] : shadow_q[slot_idx][reg_idx];
            end
        end
    end

    // Shadow writes and shadow-to-live commits (new write data bypasses into live).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int s = 0; s < SLOTS; s++) begin
                for (int r = 0; r < REGS; r++) begin
                    shadow_q[s][r] <= '0;
                    live_q[s][r]   <= '0;
                end
            end
        end else begin
            for (int s = 0; s < SLOTS; s++) begin
                for (int r = 0; r < REGS; r++) begin
                    if (wr_hit[s] && (reg_idx == RW'(r))) begin
                        shadow_q[s][r] <= data_in_i;
                    end
                    if (commit_d[s]) begin
                        live_q[s][r] <= (wr_hit[s] && (reg_idx == RW'(r))) ? data_in_i
                                                                           : shadow_q[s][r];
                    end
                end
            end
        end
    end

    // Control state: dirty flags, commit pulses and read pipeline.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dirty_q    <= '0;
            commit_q   <= '0;
            rdata_q    <= '0;
            sel_q      <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            dirty_q    <= dirty_d;
            commit_q   <= commit_d;
            rdata_q    <= rdata_d;
            sel_q      <= sel_d;
            rd_valid_q <= rden_i;
        end
    end

    // Flatten live registers onto the coprocessor bus.
    always_comb begin
        regs_out_o = '0;
        for (int s = 0; s < SLOTS; s++) begin
            for (int r = 0; r < REGS; r++) begin
                regs_out_o[(s*REGS+r)*DATA_W +: DATA_W] = live_q[s][r];
            end
        end
    end

    assign data_out_o     = sel_q ? rdata_q : dmem_q_i;
    assign rd_valid_o     = rd_valid_q;
    assign dmem_wren_o    = wren_i & ~mmio_sel;
    assign commit_pulse_o = commit_q;
    assign dirty_o        = dirty_q;

endmodule

// File: tb/tb_mmio_bank.sv
// tb/tb_mmio_bank.sv - self-checking bench for mmio_bank against a behavioural model
module tb_mmio_bank;
    localparam int SLOTS  = 16;
    localparam int REGS   = 8;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 13;
    localparam logic [SLOTS-1:0] IMM = 16'h0210;
    localparam int RB = SLOTS*REGS*DATA_W;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [ADDR_W-1:0]        address;
    logic [DATA_W-1:0]        data_in;
    logic                     wren, rden, frame_strobe;
    logic [DATA_W-1:0]        dmem_q;
    logic [SLOTS*DATA_W-1:0]  stat_in;
    logic [DATA_W-1:0]        data_out;
    logic                     rd_valid, dmem_wren;
    logic [RB-1:0]            regs_out;
    logic [SLOTS-1:0]         commit_pulse, dirty;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    logic [DATA_W-1:0] sh_m [SLOTS][REGS];
    logic [DATA_W-1:0] lv_m [SLOTS][REGS];
    logic [SLOTS-1:0]  dirty_m, commit_m;
    logic              sel_m, valid_m;
    logic [DATA_W-1:0] rdata_m;

    mmio_bank #(.SLOTS(SLOTS), .REGS(REGS), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .IMM_MASK(IMM)) dut (
        .clk_i(clk), .rst_ni(rst_n), .address_i(address), .data_in_i(data_in),
        .wren_i(wren), .rden_i(rden), .data_out_o(data_out), .rd_valid_o(rd_valid),
        .dmem_wren_o(dmem_wren), .dmem_q_i(dmem_q), .frame_strobe_i(frame_strobe),
        .stat_in_i(stat_in), .regs_out_o(regs_out), .commit_pulse_o(commit_pulse), .dirty_o(dirty)
    );

    always #5 clk = ~clk;

    function automatic logic [ADDR_W-1:0] maddr(input int slot, input int page, input int r);
        logic [ADDR_W-1:0] a;
        a = '0;
        a[12]  = 1'b1;
        a[9:6] = 4'(slot);
        a[5]   = 1'(page);
        a[4:2] = 3'(r);
        return a;
    endfunction

    function automatic logic [RB-1:0] exp_regs();
        logic [RB-1:0] v;
        for (int s = 0; s < SLOTS; s++)
            for (int r = 0; r < REGS; r++)
                v[(s*REGS+r)*DATA_W +: DATA_W] = lv_m[s][r];
        return v;
    endfunction

    function automatic int first_diff(input logic [RB-1:0] a, input logic [RB-1:0] b);
        for (int i = 0; i < SLOTS*REGS; i++)
            if (a[i*DATA_W +: DATA_W] !== b[i*DATA_W +: DATA_W]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < SLOTS; s++)
            for (int r = 0; r < REGS; r++) begin
                sh_m[s][r] = '0;
                lv_m[s][r] = '0;
            end
        dirty_m = '0; commit_m = '0; sel_m = 1'b0; valid_m = 1'b0; rdata_m = '0;
    endtask

    // Applies the bank's rules to the currently driven inputs for one clock edge.
    task automatic model_edge();
        int slot, r;
        bit mm, pg;
        if (!rst_n) return;
        mm = address[12]; pg = address[5];
        slot = int'(address[9:6]); r = int'(address[4:2]);
        valid_m = rden; commit_m = '0;
        if (rden) begin
            sel_m = mm;
            if (mm) rdata_m = pg ? stat_in[slot*DATA_W +: DATA_W] : sh_m[slot][r];
        end
        if (wren && mm && !pg) begin
            sh_m[slot][r] = data_in;
            if (IMM[slot]) begin
                lv_m[slot][r] = data_in;
                commit_m[slot] = 1'b1;
            end else begin
                dirty_m[slot] = 1'b1;
            end
        end
        if (frame_strobe)
            for (int s = 0; s < SLOTS; s++)
                if (!IMM[s] && dirty_m[s]) begin
                    for (int k = 0; k < REGS; k++) lv_m[s][k] = sh_m[s][k];
                    dirty_m[s] = 1'b0;
                    commit_m[s] = 1'b1;
                end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wren = 0; rden = 0; frame_strobe = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; wren = 1; frame_strobe = 1; rden = 0;
        address = maddr(0, 0, 0); data_in = 32'hFFFF_FFFF; dmem_q = $urandom;
        stat_in = {SLOTS{32'h1111_1111}};
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (regs_out !== '0) begin miscompares++; $display("FAIL reset_regs_out: word %0d nonzero", first_diff(regs_out, '0)); end
        vectors++; if (dirty !== '0) begin miscompares++; $display("FAIL reset_dirty: got %h want 0", dirty); end
        vectors++; if (rd_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
        vectors++; if (data_out !== dmem_q) begin miscompares++; $display("FAIL reset_data_out: got %h want %h", data_out, dmem_q); end
        rst_n = 1'b1; idle_inputs();
        tick();
        rden = 1; address = maddr(3, 0, 2);
        tick();
        idle_inputs();
        vectors++; if (rd_valid !== 1'b1) begin miscompares++; $display("FAIL reset_read_valid: got %b want 1", rd_valid); end
        vectors++; if (data_out !== 32'h0) begin miscompares++; $display("FAIL reset_read_data: got %h want 0", data_out); end
        tick();
        vectors++; if (rd_valid !== 1'b0) begin miscompares++; $display("FAIL rd_valid_single: got %b want 0", rd_valid); end
    endtask

    task automatic test_frame_commit();
        wren = 1; address = maddr(0, 0, 1); data_in = 32'hDEADBEEF;
        tick();
        idle_inputs();
        vectors++; if (dirty[0] !== 1'b1) begin miscompares++; $display("FAIL frame_dirty_set: got %b want 1", dirty[0]); end
        vectors++; if (regs_out[1*DATA_W +: DATA_W] !== 32'h0) begin miscompares++; $display("FAIL frame_live_held: got %h want 0", regs_out[1*DATA_W +: DATA_W]); end
        frame_strobe = 1;
        tick();
        idle_inputs();
        vectors++; if (regs_out[1*DATA_W +: DATA_W] !== 32'hDEADBEEF) begin miscompares++; $display("FAIL frame_live: got %h want deadbeef", regs_out[1*DATA_W +: DATA_W]); end
        vectors++; if (commit_pulse !== 16'h0001) begin miscompares++; $display("FAIL frame_commit_pulse: got %h want 0001", commit_pulse); end
        vectors++; if (dirty !== 16'h0) begin miscompares++; $display("FAIL frame_dirty_clear: got %h want 0", dirty); end
        tick();
        vectors++; if (commit_pulse !== 16'h0) begin miscompares++; $display("FAIL frame_pulse_once: got %h want 0", commit_pulse); end
    endtask

    task automatic test_immediate();
        wren = 1; address = maddr(4, 0, 0); data_in = 32'h00600168;
        tick();
        idle_inputs();
        vectors++; if (regs_out[(4*REGS)*DATA_W +: DATA_W] !== 32'h00600168) begin miscompares++; $display("FAIL imm_live: got %h want 00600168", regs_out[(4*REGS)*DATA_W +: DATA_W]); end
        vectors++; if (commit_pulse !== 16'h0010) begin miscompares++; $display("FAIL imm_commit_pulse: got %h want 0010", commit_pulse); end
        vectors++; if (dirty[4] !== 1'b0) begin miscompares++; $display("FAIL imm_dirty: got %b want 0", dirty[4]); end
        frame_strobe = 1;
        tick();
        idle_inputs();
        vectors++; if (commit_pulse !== 16'h0) begin miscompares++; $display("FAIL imm_strobe_ignored: got %h want 0", commit_pulse); end
    endtask

    task automatic test_status_dmem();
        stat_in[12*DATA_W +: DATA_W] = 32'h0000000A;
        rden = 1; address = maddr(12, 1, 0); dmem_q = 32'h5555_AAAA;
        tick();
        stat_in[12*DATA_W +: DATA_W] = 32'hFFFF_0000;
        vectors++; if (rd_valid !== 1'b1) begin miscompares++; $display("FAIL stat_valid: got %b want 1", rd_valid); end
        vectors++; if (data_out !== 32'h0000000A) begin miscompares++; $display("FAIL stat_data: got %h want 0000000a", data_out); end
        address = 13'h0ABC; wren = 1; rden = 1; data_in = $urandom;
        #1;
        vectors++; if (dmem_wren !== 1'b1) begin miscompares++; $display("FAIL dmem_wren_dmem: got %b want 1", dmem_wren); end
        tick();
        dmem_q = 32'h1357_9BDF;
        #1;
        vectors++; if (data_out !== 32'h1357_9BDF) begin miscompares++; $display("FAIL dmem_mux: got %h want 13579bdf", data_out); end
        rden = 0; wren = 1; address = maddr(5, 1, 3);
        #1;
        vectors++; if (dmem_wren !== 1'b0) begin miscompares++; $display("FAIL dmem_wren_mmio: got %b want 0", dmem_wren); end
        tick();
        idle_inputs();
        vectors++; if (dirty !== dirty_m) begin miscompares++; $display("FAIL status_write_ignored: got %h want %h", dirty, dirty_m); end
    endtask

    task automatic test_simultaneous();
        wren = 1; address = maddr(1, 0, 7); data_in = 32'h0000_0BAD;
        tick();
        wren = 1; rden = 1; frame_strobe = 1; data_in = 32'h0000_1234;
        tick();
        idle_inputs();
        vectors++; if (data_out !== 32'h0000_0BAD) begin miscompares++; $display("FAIL simul_read_old: got %h want 00000bad", data_out); end
        vectors++; if (regs_out[(1*REGS+7)*DATA_W +: DATA_W] !== 32'h0000_1234) begin miscompares++; $display("FAIL simul_live: got %h want 00001234", regs_out[(1*REGS+7)*DATA_W +: DATA_W]); end
        vectors++; if (commit_pulse[1] !== 1'b1) begin miscompares++; $display("FAIL simul_commit: got %b want 1", commit_pulse[1]); end
        vectors++; if (dirty[1] !== 1'b0) begin miscompares++; $display("FAIL simul_dirty: got %b want 0", dirty[1]); end
    endtask

    task automatic test_reset_mid_frame();
        wren = 1; address = maddr(2, 0, 3); data_in = $urandom | 32'h1;
        tick();
        idle_inputs();
        vectors++; if (dirty[2] !== 1'b1) begin miscompares++; $display("FAIL midframe_dirty: got %b want 1", dirty[2]); end
        rst_n = 1'b0;
        #2;
        vectors++; if (dirty !== '0) begin miscompares++; $display("FAIL async_reset_dirty: got %h want 0", dirty); end
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1; frame_strobe = 1;
        tick();
        idle_inputs();
        vectors++; if (commit_pulse !== '0) begin miscompares++; $display("FAIL midframe_no_commit: got %h want 0", commit_pulse); end
        vectors++; if (regs_out !== '0) begin miscompares++; $display("FAIL midframe_regs: word %0d nonzero", first_diff(regs_out, '0)); end
    endtask

    task automatic test_random();
        logic [RB-1:0] er;
        for (int i = 0; i < 600; i++) begin
            wren = ($urandom_range(0, 1) == 1);
            rden = ($urandom_range(0, 1) == 1);
            frame_strobe = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 5) == 0) address = ADDR_W'($urandom) & 13'h0FFF;
            else address = maddr($urandom_range(0, 15), $urandom_range(0, 1), $urandom_range(0, 7)) | 13'($urandom_range(0, 3));
            data_in = $urandom;
            for (int s = 0; s < SLOTS; s++) stat_in[s*DATA_W +: DATA_W] = $urandom;
            #1;
            vectors++; if (dmem_wren !== (wren & ~address[12])) begin miscompares++; $display("FAIL rand_dmem_wren[%0d]: got %b want %b", i, dmem_wren, wren & ~address[12]); end
            tick();
            dmem_q = $urandom;
            #1;
            er = exp_regs();
            vectors++; if (regs_out !== er) begin miscompares++; $display("FAIL rand_regs_out[%0d]: word %0d got %h want %h", i, first_diff(regs_out, er), regs_out[first_diff(regs_out, er)*DATA_W +: DATA_W], er[first_diff(regs_out, er)*DATA_W +: DATA_W]); end
            vectors++; if (dirty !== dirty_m) begin miscompares++; $display("FAIL rand_dirty[%0d]: got %h want %h", i, dirty, dirty_m); end
            vectors++; if (commit_pulse !== commit_m) begin miscompares++; $display("FAIL rand_commit[%0d]: got %h want %h", i, commit_pulse, commit_m); end
            vectors++; if (rd_valid !== valid_m) begin miscompares++; $display("FAIL rand_rd_valid[%0d]: got %b want %b", i, rd_valid, valid_m); end
            vectors++; if (data_out !== (sel_m ? rdata_m : dmem_q)) begin miscompares++; $display("FAIL rand_data_out[%0d]: got %h want %h", i, data_out, sel_m ? rdata_m : dmem_q); end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_frame_commit();
        test_immediate();
        test_status_dmem();
        test_simultaneous();
        test_reset_mid_frame();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mmio_bank.md
# mmio_bank

Parametrised memory-mapped register bank that replaces hand-coded MMIO decode between the CPU data port and the coprocessors (physics, controller, VGA, collision). CPU writes land in per-slot shadow registers and are committed to the live registers the coprocessors see. Commit happens either immediately or on a frame strobe, selected per slot. Reads return shadow registers or per-slot coprocessor status words with one-cycle registered latency, muxed with the data-memory path.

## Interface
- SLOTS, 16: coprocessor slots; power of two, ≥2; SW = log2(SLOTS)
- REGS, 8: registers per slot; power of two, ≥2; RW = log2(REGS)
- DATA_W, 32: register width
- ADDR_W, 13: CPU address width; must satisfy ADDR_W ≥ SW+RW+4
- IMM_MASK, {SLOTS{1'b0}}: bit s=1 puts slot s in immediate mode; bit s=0 puts it in frame mode
- clock  in  1  sole clock; all state updates on posedge
- reset  in  1  asynchronous, active-low; clears all state
- address  in  ADDR_W  CPU byte address
- data_in  in  DATA_W  CPU write data
- wren  in  1  write request, one transfer per cycle
- rden  in  1  read request
- data_out  out  DATA_W  read data
- rd_valid  out  1  one-cycle pulse, the cycle after rden
- dmem_wren  out  1  wren & ~address[ADDR_W-1]
- dmem_q  in  DATA_W  data-memory read data
- frame_strobe  in  1  single-cycle commit trigger for frame-mode slots
- stat_in  in  SLOTS*DATA_W  status word per slot; slot s occupies [s*DATA_W +: DATA_W]
- regs_out  out  SLOTS*REGS*DATA_W  live registers; slot s, register r occupies [(s*REGS+r)*DATA_W +: DATA_W]
- commit_pulse  out  SLOTS  one-cycle pulse when slot s live registers update
- dirty  out  SLOTS  slot s has uncommitted shadow writes

## Operation
- Address decode:
  - address[ADDR_W-1] = 1 selects MMIO; 0 selects dmem.
  - Register index = address[RW+1:2].
  - Page bit = address[RW+2]: 0 selects shadow, 1 selects status.
  - Slot = address[SW+RW+2:RW+3].
  - address[1:0] and all other bits are ignored.
- MMIO write to the shadow page:
  - shadow[slot][reg] ← data_in.
  - Frame-mode slots set dirty[slot].
- MMIO write to the status page: ignored; no state change.
- Immediate-mode slot: a write updates the live register on the same edge as the shadow register. commit_pulse[slot] fires the next cycle. dirty stays 0.
- Frame-mode slot: on a frame_strobe cycle, every slot with dirty=1 (or with a write in that cycle) copies all REGS shadow registers to live. Its dirty clears and commit_pulse fires for one cycle. Slots with no pending writes do not pulse.
- Read: on rden with the MMIO bit set, the bank captures the value selected by the page bit:
  - page 0: shadow[slot][reg];
  - page 1: stat_in for the slot.
- The read-path select registers the MMIO bit at rden. data_out = sel_q ? rdata_q : dmem_q.
- Status page is read-only; the shadow page is read/write.

## Timing
- Reset (asynchronous assert, release synchronous to clock):
  - shadow, live, rdata_q, sel_q, dirty, commit_pulse and rd_valid all return to 0.
  - data_out therefore shows dmem_q.
  - Pending commits are discarded.
- Read latency is one cycle; rd_valid is high exactly one cycle per accepted rden. Back-to-back reads every cycle are supported.
- Write with a read of the same shadow address in the same cycle: the read returns the pre-write value.
- Write and frame_strobe in the same cycle to a frame-mode slot: the commit includes the new write value, and dirty ends at 0.
- frame_strobe has no effect on immediate-mode slots.
- A frame_strobe held high for N cycles commits on each cycle that has dirty slots; no other interaction.
- The status capture samples stat_in on the rden edge.
- regs_out changes only on commit edges and is stable between them.
- wren and rden together are legal; both take effect.

## Test plan
- Reset with wren and frame_strobe active, then release:
  - all regs_out = 0, dirty = 0, rd_valid = 0;
  - a read of slot 3 reg 2 returns 0.
- Frame-mode commit (slot 0):
  - Write 0xDEADBEEF to slot 0 reg 1. dirty[0]=1 and regs_out is unchanged.
  - Pulse frame_strobe. The next cycle regs_out slot0/reg1 = 0xDEADBEEF, commit_pulse[0]=1 for one cycle, dirty[0]=0.
- Immediate-mode commit (IMM_MASK bit 4 set):
  - Write 0x00600168 to slot 4 reg 0.
  - Live updates on the same edge, commit_pulse[4] the next cycle, no frame_strobe needed, dirty[4] stays 0.
- Status read and dmem mux:
  - stat_in slot 12 = 0x0000000A. Read slot 12 page 1: data_out = 0x0A with rd_valid one cycle later.
  - A following read with address[ADDR_W-1]=0 shows dmem_q. dmem_wren follows wren only for dmem addresses.
- Simultaneous events:
  - Write 0x1234 to slot 1 reg 7 while reading the same address and pulsing frame_strobe.
  - The read returns the old value; regs_out slot1/reg7 = 0x1234 next cycle; commit_pulse[1]=1.
- Reset mid-frame: write slot 2 (dirty[2]=1), assert reset, release, pulse frame_strobe → no commit_pulse, regs_out slot2 = 0.
